// File: rtl/dmem_pkg.sv
// Shared types and constants for the dmem arbiter and its lane decoder.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'd0,
    SZ_HALF    = 2'd1,
    SZ_WORD    = 2'd2,
    SZ_ILLEGAL = 2'd3
  } size_e;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StRmwWr = 1'b1
  } arb_state_e;

  localparam int unsigned RMEM_SIGNED = 4;
  localparam logic [3:0]  WMEM_WORD   = 4'b1111;
  localparam logic [4:0]  RMEM_WORD   = 5'b01111;

  // Expands a 4-bit lane mask into a 32-bit byte mask.
  function automatic logic [31:0] lane_bytes(input logic [3:0] mask);
    return {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
  endfunction

endpackage

// File: rtl/dmem_lane_decode.sv
// Combinational decode of one byte-addressed request into dmem lane mask,
// read/write codes, the error flag and the lane-shifted store bytes.
module dmem_lane_decode
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 15
) (
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [3:0]  mask,
  output logic        err,
  output logic [3:0]  wmem_code,
  output logic [4:0]  rmem_code,
  output logic [31:0] wdata_lane
);

  logic bad_shape;
  logic out_of_range;

  assign out_of_range = |(addr >> (ADDR_WIDTH + 2));

  always_comb begin
    mask      = 4'b0000;
    bad_shape = 1'b0;
    unique case (size)
      SZ_BYTE: mask = 4'b0001 << addr[1:0];
      SZ_HALF: begin
        mask      = 4'b0011 << {addr[1], 1'b0};
        bad_shape = addr[0];
      end
      SZ_WORD: begin
        mask      = WMEM_WORD;
        bad_shape = |addr[1:0];
      end
      default: bad_shape = 1'b1;
    endcase
  end

  assign err        = bad_shape | out_of_range;
  assign wmem_code  = (we && !err) ? mask : 4'b0000;
  assign rmem_code  = (!we && !err) ? {sign_ext & (size != SZ_WORD), mask} : 5'b00000;
  assign wdata_lane = wdata << {addr[1:0], 3'b000};

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing dmem between the LSU (port 0) and the debug loader (port 1).
// Define DMEM_ARB_RMW_EN to sequence sub-word stores as read-modify-write.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_we,
  input  logic [3:0]  req_size,
  input  logic [1:0]  req_signed,
  input  logic [63:0] req_wdata,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [3:0]  wmem,
  output logic [4:0]  rmem,
  output logic [31:0] store_data,
  input  logic [31:0] load_data
);

  arb_state_e  state_q, state_d;
  logic        last_q, last_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [1:0]  rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic [1:0]  grant;
  logic        sel;
  logic [31:0] sel_addr, sel_wdata, word_addr;
  logic [1:0]  sel_size;
  logic        sel_we, sel_signed;

  logic [3:0]  dec_mask, dec_wmem;
  logic [4:0]  dec_rmem;
  logic        dec_err;
  logic [31:0] dec_wdata_lane;

  // Port != last wins a conflict; a lone requester always wins.
  always_comb begin
    grant = 2'b00;
    sel   = 1'b0;
    if (!rst && state_q == StIdle && |req_valid) begin
      sel   = (req_valid == 2'b11) ? ~last_q : req_valid[1];
      grant = sel ? 2'b10 : 2'b01;
    end
  end

  assign req_ready  = grant;
  assign last_d     = |grant ? sel : last_q;
  assign sel_addr   = sel ? req_addr[63:32] : req_addr[31:0];
  assign sel_wdata  = sel ? req_wdata[63:32] : req_wdata[31:0];
  assign sel_size   = sel ? req_size[3:2] : req_size[1:0];
  assign sel_we     = sel ? req_we[1] : req_we[0];
  assign sel_signed = sel ? req_signed[1] : req_signed[0];
  assign word_addr  = {{(32 - ADDR_WIDTH){1'b0}}, sel_addr[ADDR_WIDTH+1:2]};

  dmem_lane_decode #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_decode (
    .addr       (sel_addr),
    .size       (sel_size),
    .sign_ext   (sel_signed),
    .we         (sel_we),
    .wdata      (sel_wdata),
    .mask       (dec_mask),
    .err        (dec_err),
    .wmem_code  (dec_wmem),
    .rmem_code  (dec_rmem),
    .wdata_lane (dec_wdata_lane)
  );

`ifdef DMEM_ARB_RMW_EN
  logic [31:0] merge_q, merge_d;
  logic [31:0] lane_data_q, lane_data_d;
  logic [3:0]  lane_mask_q, lane_mask_d;
  logic        port_q, port_d;
  logic        rmw_start;

  assign rmw_start = sel_size != SZ_WORD;
`else
  logic unused_lane;
  assign unused_lane = ^{dec_mask, dec_wdata_lane};
`endif

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    wmem        = 4'b0000;
    rmem        = 5'b00000;
    store_data  = 32'h0;
    rsp_valid_d = 2'b00;
    rsp_rdata_d = 32'h0;
    rsp_err_d   = 1'b0;
`ifdef DMEM_ARB_RMW_EN
    merge_d     = merge_q;
    lane_data_d = lane_data_q;
    lane_mask_d = lane_mask_q;
    port_d      = port_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (|grant) begin
          rsp_valid_d = grant;
          rsp_err_d   = dec_err;
          if (!dec_err) begin
            mem_addr_d = word_addr;
            if (!sel_we) begin
              rmem        = dec_rmem;
              rsp_rdata_d = load_data;
`ifdef DMEM_ARB_RMW_EN
            end else if (rmw_start) begin
              // Read the whole word now, write the merged word next cycle.
              rmem        = RMEM_WORD;
              rsp_valid_d = 2'b00;
              merge_d     = load_data;
              lane_data_d = dec_wdata_lane;
              lane_mask_d = dec_mask;
              port_d      = sel;
              state_d     = StRmwWr;
`endif
            end else begin
              wmem       = dec_wmem;
              store_data = sel_wdata;
            end
          end
        end
      end
`ifdef DMEM_ARB_RMW_EN
      StRmwWr: begin
        wmem        = WMEM_WORD;
        store_data  = (merge_q & ~lane_bytes(lane_mask_q)) |
                      (lane_data_q & lane_bytes(lane_mask_q));
        rsp_valid_d = port_q ? 2'b10 : 2'b01;
        state_d     = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
    if (rst) begin
      wmem       = 4'b0000;
      rmem       = 5'b00000;
      store_data = 32'h0;
    end
    mem_addr = mem_addr_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      last_q      <= 1'b1;
      mem_addr_q  <= 32'h0;
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      mem_addr_q  <= mem_addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

`ifdef DMEM_ARB_RMW_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      merge_q     <= 32'h0;
      lane_data_q <= 32'h0;
      lane_mask_q <= 4'b0000;
      port_q      <= 1'b0;
    end else begin
      merge_q     <= merge_d;
      lane_data_q <= lane_data_d;
      lane_mask_q <= lane_mask_d;
      port_q      <= port_d;
    end
  end
`endif

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a dmem model on the memory side and a byte-array
// reference model of the requesters' view of memory.
module tb_dmem_arbiter;

  localparam int unsigned AW    = 15;
  localparam int unsigned NWORD = 1 << AW;
  localparam int unsigned SPAN  = 4 * NWORD;
`ifdef DMEM_ARB_RMW_EN
  localparam bit          RMW       = 1'b1;
  localparam logic [31:0] EXP_MERGE = 32'h1122AA44;
`else
  localparam bit          RMW       = 1'b0;
  localparam logic [31:0] EXP_MERGE = 32'h0000AA00;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, req_we, req_signed, rsp_valid;
  logic [63:0] req_addr, req_wdata;
  logic [3:0]  req_size, wmem;
  logic [31:0] rsp_rdata, mem_addr, store_data, load_data;
  logic        rsp_err;
  logic [4:0]  rmem;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_WIDTH (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_addr   (mem_addr),
    .wmem       (wmem),
    .rmem       (rmem),
    .store_data (store_data),
    .load_data  (load_data)
  );

  // dmem: places the low byte/half into the masked lane and zeroes the rest.
  bit [31:0] dmem [NWORD];

  function automatic logic [31:0] place(input logic [3:0] m, input logic [31:0] d);
    case (m)
      4'b0001: return {24'd0, d[7:0]};
      4'b0010: return {16'd0, d[7:0], 8'd0};
      4'b0100: return {8'd0, d[7:0], 16'd0};
      4'b1000: return {d[7:0], 24'd0};
      4'b0011: return {16'd0, d[15:0]};
      4'b1100: return {d[15:0], 16'd0};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] pick(input logic [4:0] r, input logic [31:0] w);
    logic [31:0] v;
    int nb;
    nb = 8;
    case (r[3:0])
      4'b0001: v = {24'd0, w[7:0]};
      4'b0010: v = {24'd0, w[15:8]};
      4'b0100: v = {24'd0, w[23:16]};
      4'b1000: v = {24'd0, w[31:24]};
      4'b0011: begin v = {16'd0, w[15:0]};  nb = 16; end
      4'b1100: begin v = {16'd0, w[31:16]}; nb = 16; end
      default: begin v = w; nb = 32; end
    endcase
    if (r[4] && nb == 8 && v[7]) v[31:8] = 24'hFFFFFF;
    if (r[4] && nb == 16 && v[15]) v[31:16] = 16'hFFFF;
    return v;
  endfunction

  always @(posedge clk) if (wmem != 4'd0) dmem[mem_addr[AW-1:0]] <= place(wmem, store_data);
  always_comb load_data = pick(rmem, dmem[mem_addr[AW-1:0]]);

  // Reference model state.
  typedef struct {bit v; bit we; bit [1:0] sz; bit sg; bit [31:0] a; bit [31:0] d;} req_t;
  typedef struct {int due; int port; bit [31:0] data; bit err;} rsp_t;

  bit [7:0]  ref_mem [SPAN];
  bit [7:0]  undo [4];
  int        undo_a;
  req_t      cur [2];
  rsp_t      exp_q [$];
  int        grants [$];
  int        cyc = 0, last_m = 1, n_cmp = 0, n_bad = 0, fill_pct = 0;
  bit        blk = 1'b0, loads_only = 1'b0;
  bit [31:0] last_data;
  bit        last_err;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit is_err(input req_t r);
    return r.sz == 2'd3 || (r.sz == 2'd1 && r.a[0]) || (r.sz == 2'd2 && r.a[1:0] != 2'd0) ||
           r.a >= SPAN;
  endfunction

  function automatic logic [31:0] ref_load(input req_t r);
    logic [31:0] v;
    int n;
    n = 1 << r.sz;
    v = 32'h0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[int'(r.a) + k];
    if (r.sg && n < 4 && v[8*n-1]) for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic ref_store(input req_t r);
    int n, base;
    n    = 1 << r.sz;
    base = int'(r.a) & ~3;
    if (!RMW && n < 4) for (int k = 0; k < 4; k++) ref_mem[base + k] = 8'h00;
    for (int k = 0; k < n; k++) ref_mem[int'(r.a) + k] = r.d[8*k +: 8];
  endtask

  function automatic req_t rand_req();
    req_t r;
    int   pa;
    r.v  = 1'b1;
    r.we = loads_only ? 1'b0 : 1'($urandom_range(0, 1));
    r.sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    r.sg = 1'($urandom_range(0, 1));
    r.d  = $urandom;
    pa   = $urandom_range(0, 19);
    if (pa == 0) r.a = $urandom;
    else if (pa == 1) r.a = SPAN - 32'($urandom_range(1, 4));
    else r.a = 32'($urandom_range(0, 63));
    if (pa > 3) begin
      if (r.sz == 2'd1) r.a[0] = 1'b0;
      else if (r.sz == 2'd2) r.a[1:0] = 2'd0;
    end
    return r;
  endfunction

  task automatic apply_inputs();
    for (int i = 0; i < 2; i++) begin
      req_valid[i]         = cur[i].v;
      req_we[i]            = cur[i].we;
      req_signed[i]        = cur[i].sg;
      req_size[2*i +: 2]   = cur[i].sz;
      req_addr[32*i +: 32] = cur[i].a;
      req_wdata[32*i +: 32] = cur[i].d;
    end
  endtask

  task automatic refill();
    for (int i = 0; i < 2; i++)
      if (!cur[i].v && $urandom_range(0, 99) < fill_pct) cur[i] = rand_req();
  endtask

  task automatic check_rsp();
    rsp_t       e;
    logic [1:0] oh;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e  = exp_q.pop_front();
      oh = (e.port == 1) ? 2'b10 : 2'b01;
      check_eq("rsp_valid", 32'(rsp_valid), 32'(oh));
      check_eq("rsp_rdata", rsp_rdata, e.data);
      check_eq("rsp_err", 32'(rsp_err), 32'(e.err));
      last_data = rsp_rdata;
      last_err  = rsp_err;
    end else begin
      check_eq("rsp_idle", 32'(rsp_valid), 32'd0);
    end
  endtask

  // One clock: drive at posedge+1, check at negedge, advance the model.
  task automatic step();
    int         g;
    logic [1:0] exp_ready;
    bit         rmw;
    req_t       r;
    apply_inputs();
    @(negedge clk);
    if (blk) check_eq("rmw_wmem", 32'(wmem), 32'hF);
    g = -1;
    if (!blk) begin
      if (cur[0].v && cur[1].v) g = (last_m == 0) ? 1 : 0;
      else if (cur[0].v) g = 0;
      else if (cur[1].v) g = 1;
    end
    exp_ready = (g < 0) ? 2'b00 : ((g == 1) ? 2'b10 : 2'b01);
    check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
    check_rsp();
    rmw = 1'b0;
    if (g >= 0) begin
      r = cur[g];
      if (is_err(r)) begin
        check_eq("err_wmem", 32'(wmem), 32'd0);
        check_eq("err_rmem", 32'(rmem), 32'd0);
        exp_q.push_back('{cyc + 1, g, 32'h0, 1'b1});
      end else if (!r.we) begin
        exp_q.push_back('{cyc + 1, g, ref_load(r), 1'b0});
      end else begin
        rmw = RMW && r.sz != 2'd2;
        if (rmw) begin
          undo_a = int'(r.a) & ~3;
          for (int k = 0; k < 4; k++) undo[k] = ref_mem[undo_a + k];
        end
        ref_store(r);
        exp_q.push_back('{cyc + (rmw ? 2 : 1), g, 32'h0, 1'b0});
      end
      cur[g].v = 1'b0;
      last_m   = g;
      grants.push_back(g);
    end
    blk = rmw;
    @(posedge clk);
    #1;
    cyc++;
    refill();
  endtask

  task automatic do_reset(input int n);
    rst      = 1'b1;
    cur[0].v = 1'b0;
    cur[1].v = 1'b0;
    for (int k = 0; k < n; k++) begin
      apply_inputs();
      @(negedge clk);
      check_eq("rst_ready", 32'(req_ready), 32'd0);
      check_eq("rst_wmem", 32'(wmem), 32'd0);
      check_eq("rst_rmem", 32'(rmem), 32'd0);
      if (k == 0) check_rsp();
      @(posedge clk);
      #1;
      cyc++;
    end
    if (blk) for (int k = 0; k < 4; k++) ref_mem[undo_a + k] = undo[k];
    blk    = 1'b0;
    last_m = 1;
    exp_q.delete();
    rst = 1'b0;
    apply_inputs();
    @(negedge clk);
    check_eq("post_rst_valid", 32'(rsp_valid), 32'd0);
    check_eq("post_rst_rdata", rsp_rdata, 32'd0);
    check_eq("post_rst_err", 32'(rsp_err), 32'd0);
    check_eq("post_rst_addr", mem_addr, 32'd0);
    check_eq("post_rst_sdata", store_data, 32'd0);
    check_eq("post_rst_wmem", 32'(wmem | 4'(rmem)), 32'd0);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    int n;
    n        = 0;
    fill_pct = 0;
    while ((cur[0].v || cur[1].v || exp_q.size() > 0) && n < 50) begin
      step();
      n++;
    end
    check_eq("drain_left", 32'(exp_q.size()) + 32'(cur[0].v) + 32'(cur[1].v), 32'd0);
  endtask

  task automatic run_one(input int p, input bit we, input bit [1:0] sz, input bit sg,
                         input bit [31:0] a, input bit [31:0] d);
    cur[p] = '{1'b1, we, sz, sg, a, d};
    drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    cur[0] = '{1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0};
    cur[1] = cur[0];
    do_reset(3);

    // Both ports valid continuously: grants alternate from port 0.
    loads_only = 1'b1;
    fill_pct   = 100;
    grants.delete();
    refill();
    repeat (6) step();
    for (int k = 0; k < 6; k++) check_eq("alt_grant", 32'(grants[k]), 32'(k % 2));
    drain();
    loads_only = 1'b0;

    run_one(0, 1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF);
    run_one(0, 1'b0, 2'd0, 1'b1, 32'h103, 32'h0);
    check_eq("sbyte_load", last_data, 32'hFFFFFFDE);

    run_one(0, 1'b1, 2'd2, 1'b0, 32'h40, 32'h11223344);
    run_one(0, 1'b1, 2'd0, 1'b0, 32'h41, 32'h000000AA);
    run_one(0, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    check_eq("merge_word", last_data, EXP_MERGE);

    run_one(0, 1'b0, 2'd1, 1'b0, 32'h203, 32'h0);
    check_eq("half_misalign", 32'(last_err), 32'd1);
    run_one(1, 1'b1, 2'd2, 1'b0, 32'h206, 32'h12345678);
    check_eq("word_misalign", 32'(last_err), 32'd1);
    run_one(0, 1'b0, 2'd2, 1'b0, 32'h00020000, 32'h0);
    check_eq("out_of_range", 32'(last_err), 32'd1);
    check_eq("oor_rdata", last_data, 32'd0);

    // Reset during the write cycle of a sub-word store.
    cur[0] = '{1'b1, 1'b1, 2'd0, 1'b0, 32'h41, 32'h00000055};
    step();
    do_reset(2);
    cur[0] = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0};
    cur[1] = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0};
    grants.delete();
    step();
    check_eq("first_conflict", 32'(grants[0]), 32'd0);
    drain();

    fill_pct = 50;
    refill();
    repeat (3000) step();
    drain();
    fill_pct = 100;
    refill();
    repeat (2000) step();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
